// File: rtl/if_stage.sv
// Instruction-fetch stage: word-indexed PC, IF/ID pipeline register and a RUN/HALTED FSM.
// Branch redirect takes priority over freeze. An optional halt is raised on a fetched all-zero word.
module if_stage #(
    parameter int WORD_WIDTH   = 32,
    parameter int HALT_ON_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_addr,
    output logic [WORD_WIDTH-1:0] imem_addr,
    input  logic [WORD_WIDTH-1:0] imem_instr,
    output logic [WORD_WIDTH-1:0] if_id_pc,
    output logic [WORD_WIDTH-1:0] if_id_instr,
    output logic                  if_id_valid,
    output logic                  halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic HALT_EN = (HALT_ON_ZERO != 0);

    state_t                  state_q, state_d;
    logic [WORD_WIDTH-1:0]   pc_q, pc_d;
    logic [WORD_WIDTH-1:0]   if_pc_q, if_pc_d;
    logic [WORD_WIDTH-1:0]   if_instr_q, if_instr_d;
    logic                    if_valid_q, if_valid_d;
    logic [WORD_WIDTH-1:0]   pc_inc;
    logic                    instr_zero;

    // Wraps naturally at the register width.
    assign pc_inc     = pc_q + {{(WORD_WIDTH-1){1'b0}}, 1'b1};
    assign instr_zero = (imem_instr == '0);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        unique case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_instr_d = '0;
                    if_valid_d = 1'b0;
                end else if (freeze) begin
                    // Hazard stall: everything holds.
                end else if (HALT_EN && instr_zero) begin
                    if_pc_d    = pc_inc;
                    if_instr_d = imem_instr;
                    if_valid_d = 1'b0;
                    state_d    = HALTED;
                end else begin
                    pc_d       = pc_inc;
                    if_pc_d    = pc_inc;
                    if_instr_d = imem_instr;
                    if_valid_d = 1'b1;
                end
            end

            HALTED: begin
                // Only a redirect leaves HALTED; freeze has no effect here.
                if_valid_d = 1'b0;
                if (branch_taken) begin
                    pc_d       = branch_addr;
                    if_instr_d = '0;
                    state_d    = RUN;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_instr = if_instr_q;
    assign if_id_valid = if_valid_q;
    assign halted      = (state_q == HALTED);

endmodule
